// File: rtl/push_engine.sv
// Sokoban move/push engine: reads the person cell and up to two cells ahead in GRAM,
// applies the push rules, writes back changed cells and tracks person, holes, steps and win.
module push_engine #(
    parameter int COLS  = 20,
    parameter int ROWS  = 15,
    parameter int CELLS = 300
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init,
    input  logic [7:0]                 hole_in,
    input  logic [$clog2(CELLS)-1:0]   person_in,
    input  logic                       move_req,
    input  logic [1:0]                 dir,
    output logic [$clog2(CELLS)-1:0]   gram_addr,
    output logic                       gram_we,
    output logic [3:0]                 gram_din,
    input  logic [3:0]                 gram_dout,
    output logic                       busy,
    output logic                       move_done,
    output logic                       moved,
    output logic [$clog2(CELLS)-1:0]   person,
    output logic [7:0]                 hole,
    output logic [15:0]                steps,
    output logic                       win
);

    localparam int AW = $clog2(CELLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_P, S_RD_N1, S_RD_N2, S_EVAL, S_WR_P, S_WR_N1, S_WR_N2, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      dir_q, dir_d;
    logic [3:0]      cp_q, cp_d, c1_q, c1_d, c2_q, c2_d;
    logic            ok_q, ok_d, push_q, push_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      din_q, din_d;
    logic [AW-1:0]   person_q, person_d;
    logic [7:0]      hole_q, hole_d;
    logic [15:0]     steps_q, steps_d;
    logic            win_q, win_d;

    // Returns {oob, address}; row/col found by repeated subtraction so edges never wrap.
    function automatic logic [AW:0] step_addr(input logic [AW-1:0] a, input logic [1:0] d);
        logic [AW-1:0] rem;
        logic [RW-1:0] row;
        logic [AW:0]   res;
        rem = a;
        row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rem >= COLS_A) begin
                rem = rem - COLS_A;
                row = row + RW'(1);
            end
        end
        res = {1'b1, {AW{1'b0}}};
        unique case (d)
            2'd0: if (row != '0)             res = {1'b0, a - COLS_A};
            2'd1: if (row < RW'(ROWS - 1))   res = {1'b0, a + COLS_A};
            2'd2: if (rem != '0)             res = {1'b0, a - AW'(1)};
            default: if (rem < AW'(COLS - 1)) res = {1'b0, a + AW'(1)};
        endcase
        return res;
    endfunction

    logic [AW:0]   n1_s, n2_s;
    logic [AW-1:0] n1, n2;
    logic          oob1, oob2;
    logic [3:0]    c2_now;
    logic          walk, push;
    logic [7:0]    hole_new;

    assign n1_s   = step_addr(person_q, dir_q);
    assign n2_s   = step_addr(n1_s[AW-1:0], dir_q);
    assign n1     = n1_s[AW-1:0];
    assign n2     = n2_s[AW-1:0];
    assign oob1   = n1_s[AW];
    assign oob2   = oob1 | n2_s[AW];
    assign c2_now = oob2 ? 4'd1 : gram_dout;
    assign walk   = (c1_q == 4'd0) || (c1_q == 4'd6);
    assign push   = ((c1_q == 4'd2) || (c1_q == 4'd3)) && ((c2_now == 4'd0) || (c2_now == 4'd6));
    assign hole_new = hole_q - 8'(push_q && (c2_q == 4'd6)) + 8'(push_q && (c1_q == 4'd3));

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cp_d     = cp_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        ok_d     = ok_q;
        push_d   = push_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        din_d    = din_q;
        person_d = person_q;
        hole_d   = hole_q;
        steps_d  = steps_q;
        win_d    = win_q;
        unique case (state_q)
            S_IDLE: begin
                if (move_req && !win_q) begin
                    state_d = S_RD_P;
                    dir_d   = dir;
                    addr_d  = person_q;
                end
            end
            S_RD_P: begin
                state_d = S_RD_N1;
                if (!oob1) addr_d = n1;
            end
            S_RD_N1: begin
                state_d = S_RD_N2;
                cp_d    = gram_dout;
                if (!oob2) addr_d = n2;
            end
            S_RD_N2: begin
                state_d = S_EVAL;
                c1_d    = oob1 ? 4'd1 : gram_dout;
            end
            S_EVAL: begin
                c2_d   = c2_now;
                ok_d   = walk || push;
                push_d = push;
                if (walk || push) begin
                    state_d = S_WR_P;
                    we_d    = 1'b1;
                    addr_d  = person_q;
                    din_d   = (cp_q == 4'd5) ? 4'd6 : 4'd0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR_P: begin
                state_d = S_WR_N1;
                we_d    = 1'b1;
                addr_d  = n1;
                din_d   = ((c1_q == 4'd6) || (c1_q == 4'd3)) ? 4'd5 : 4'd4;
            end
            S_WR_N1: begin
                if (push_q) begin
                    state_d = S_WR_N2;
                    we_d    = 1'b1;
                    addr_d  = n2;
                    din_d   = (c2_q == 4'd6) ? 4'd3 : 4'd2;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR_N2: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                if (ok_q) begin
                    person_d = n1;
                    hole_d   = hole_new;
                    steps_d  = (steps_q == 16'hFFFF) ? steps_q : steps_q + 16'd1;
                    win_d    = (hole_new == 8'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A reload from the loader abandons whatever move is in flight.
        if (init) begin
            state_d  = S_IDLE;
            we_d     = 1'b0;
            person_d = person_in;
            hole_d   = hole_in;
            steps_d  = 16'd0;
            win_d    = (hole_in == 8'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 2'd0;
            cp_q     <= 4'd0;
            c1_q     <= 4'd0;
            c2_q     <= 4'd0;
            ok_q     <= 1'b0;
            push_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            din_q    <= 4'd0;
            person_q <= '0;
            hole_q   <= 8'd0;
            steps_q  <= 16'd0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cp_q     <= cp_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            ok_q     <= ok_d;
            push_q   <= push_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            din_q    <= din_d;
            person_q <= person_d;
            hole_q   <= hole_d;
            steps_q  <= steps_d;
            win_q    <= win_d;
        end
    end

    assign gram_addr = addr_q;
    assign gram_we   = we_q;
    assign gram_din  = din_q;
    assign busy      = (state_q != S_IDLE);
    assign move_done = (state_q == S_DONE);
    assign moved     = (state_q == S_DONE) && ok_q;
    assign person    = person_q;
    assign hole      = hole_q;
    assign steps     = steps_q;
    assign win       = win_q;

endmodule
